conv_out_collector: RTL and testbench

//  Sits directly downstream of conv_top and consumes its data_out/data_out_valid beats
//  (8 x int8 channels per beat, one output group per conv_top run). conv_top has no

---
 rtl/conv_out_collector.sv | 102 ++++++++++
 tb/tb_conv_out_collector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/conv_out_collector.sv
// conv_out_collector: absorbs conv_top output beats in a FIFO and writes them to memory in HWC order
module conv_out_collector #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 20,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_out_base_addr,
  input  logic [9:0]        cfg_co_groups,
  input  logic [9:0]        cfg_output_group,
  input  logic [CNT_W-1:0]  cfg_out_pixels,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  input  logic              conv_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              count_err,
  output logic [CNT_W-1:0]  beat_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wp, rp;
  logic [ADDR_W-1:0] addr_ptr;
  logic [9:0] co_groups;
  logic [CNT_W-1:0] pixels, cnt_nx;
  logic active, beat, in_ok, empty, full, out_free, pop, byp, push, load;
  assign active   = state == COLLECT || state == DRAIN;
  assign beat     = active && data_in_valid;
  assign in_ok    = beat && beat_count < pixels;
  assign empty    = wp == rp;
  assign full     = wp == {~rp[PW], rp[PW-1:0]};
  assign out_free = !wr_valid || wr_ready;
  assign pop      = out_free && !empty;
  // an empty FIFO with a free output stage lets the beat go straight to the output register
  assign byp      = out_free && empty && in_ok;
  assign push     = in_ok && (!full || pop) && !byp;
  assign load     = pop || byp;
  assign cnt_nx   = (beat && beat_count != '1) ? beat_count + 1'b1 : beat_count;
  assign busy     = active;
  assign done     = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? COLLECT : IDLE;
      COLLECT: state_nx = (cnt_nx >= pixels || conv_done) ? DRAIN : COLLECT;
      DRAIN:   state_nx = (empty && !wr_valid && !in_ok) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= data_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      addr_ptr   <= '0;
      co_groups  <= '0;
      pixels     <= '0;
      beat_count <= '0;
      overflow   <= 1'b0;
      count_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (load) begin
        wr_valid <= 1'b1;
        wr_addr  <= addr_ptr;
        wr_data  <= pop ? mem[rp[PW-1:0]] : data_in;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end
      if (state == IDLE && start) begin
        co_groups  <= cfg_co_groups;
        pixels     <= cfg_out_pixels;
        beat_count <= '0;
        overflow   <= 1'b0;
        count_err  <= 1'b0;
        addr_ptr   <= cfg_out_base_addr + ADDR_W'(cfg_output_group);
      end else begin
        beat_count <= cnt_nx;
        if (load) addr_ptr <= addr_ptr + ADDR_W'(co_groups);
        if (in_ok && full && !pop) overflow <= 1'b1;
        if ((beat && beat_count >= pixels) || (state == COLLECT && conv_done && cnt_nx < pixels))
          count_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_conv_out_collector.sv
// tb_conv_out_collector: directed runs with random data/ready against a write-list reference model
module tb_conv_out_collector;
  logic        clk = 0, rst_n = 0, start = 0, data_in_valid = 0, conv_done = 0, wr_ready = 1;
  logic [19:0] cfg_out_base_addr = '0;
  logic [9:0]  cfg_co_groups = '0, cfg_output_group = '0;
  logic [15:0] cfg_out_pixels = '0;
  logic [63:0] data_in = '0;
  logic [19:0] wr_addr;
  logic [63:0] wr_data;
  logic        wr_valid, busy, done, overflow, count_err;
  logic [15:0] beat_count;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [83:0] got_q[$];
  logic [63:0] sent[$];
  int seen[64];
  logic p_stall = 0;
  logic [19:0] p_addr = '0;
  logic [63:0] p_data = '0;

  always #5 clk = ~clk;

  conv_out_collector dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_out_base_addr(cfg_out_base_addr), .cfg_co_groups(cfg_co_groups),
    .cfg_output_group(cfg_output_group), .cfg_out_pixels(cfg_out_pixels),
    .data_in(data_in), .data_in_valid(data_in_valid), .conv_done(conv_done),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .overflow(overflow), .count_err(count_err),
    .beat_count(beat_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write monitor plus hold-while-stalled check
  always @(posedge clk) begin
    if (!rst_n) p_stall = 1'b0;
    else begin
      if (p_stall) begin
        chk("hold_valid", 64'(wr_valid), 64'd1);
        chk("hold_addr", 64'(wr_addr), 64'(p_addr));
        chk("hold_data", wr_data, p_data);
      end
      if (wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
      if (done) done_cnt++;
      p_stall = wr_valid && !wr_ready;
      p_addr  = wr_addr;
      p_data  = wr_data;
    end
  end

  // mode: 0 ready always, 1 random ready + gaps, 2 ready low during input
  task automatic run(input string tag, input logic [19:0] base, input logic [9:0] co,
                     input logic [9:0] og, input logic [15:0] pix, input int nb,
                     input bit early, input int mode, input bit poke);
    int d0, m, k;
    logic [19:0] ea;
    got_q.delete();
    sent.delete();
    d0 = done_cnt;
    @(negedge clk);
    cfg_out_base_addr = base;
    cfg_co_groups = co;
    cfg_output_group = og;
    cfg_out_pixels = pix;
    start = 1;
    wr_ready = (mode == 2) ? 1'b0 : 1'b1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < nb; i++) begin
      data_in = {$urandom, $urandom};
      data_in_valid = 1;
      sent.push_back(data_in);
      if (poke && i == 1) begin
        start = 1;
        cfg_out_base_addr = 20'h0ABCD;
        cfg_output_group = 10'd7;
        cfg_co_groups = 10'd1;
        cfg_out_pixels = 16'd2;
      end
      if (mode == 1) wr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      data_in_valid = 0;
      start = 0;
      if (i == 0 && mode != 1) chk({tag, "_latency"}, 64'(wr_valid), 64'd1);
      if (mode == 1)
        repeat ($urandom_range(0, 2)) begin
          wr_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
    end
    if (early) begin
      conv_done = 1;
      @(negedge clk);
      conv_done = 0;
    end
    for (int c = 0; c < 500 && done_cnt == d0; c++) begin
      wr_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
    wr_ready = 1;
    repeat (3) @(negedge clk);
    m = (nb < int'(pix)) ? nb : int'(pix);
    k = (mode == 2 && m > 17) ? 17 : m;
    chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(k));
    for (int i = 0; i < got_q.size() && i < k; i++) begin
      ea = base + 20'(og) + 20'(i) * 20'(co);
      chk({tag, "_addr"}, 64'(got_q[i][83:64]), 64'(ea));
      chk({tag, "_data"}, got_q[i][63:0], sent[i]);
    end
    chk({tag, "_overflow"}, 64'(overflow), 64'(mode == 2 && m > 17));
    chk({tag, "_count_err"}, 64'(count_err), 64'(nb != int'(pix)));
    chk({tag, "_beat_count"}, 64'(beat_count), 64'(nb));
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_flags", 64'({overflow, count_err}), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    run("basic", 20'h100, 10'd16, 10'd3, 16'd4, 4, 0, 0, 0);

    foreach (seen[i]) seen[i] = 0;
    for (int g = 0; g < 16; g++) begin
      run("sweep", 20'h100, 10'd16, 10'(g), 16'd4, 4, 0, 0, 0);
      foreach (got_q[i])
        if (got_q[i][83:64] >= 20'h100 && got_q[i][83:64] < 20'h140)
          seen[int'(got_q[i][83:64] - 20'h100)]++;
    end
    for (int a = 0; a < 64; a++) chk("sweep_cover", 64'(seen[a]), 64'd1);

    run("backpressure", 20'h400, 10'd2, 10'd1, 16'd20, 20, 0, 2, 0);
    run("short", 20'h800, 10'd8, 10'd5, 16'd4, 2, 1, 0, 0);
    run("extra", 20'h900, 10'd3, 10'd0, 16'd4, 5, 0, 0, 0);
    for (int r = 0; r < 3; r++)
      run("rand_ready", 20'(($urandom_range(0, 1) << 19) | 32'hFFFF0), 10'(1 + $urandom_range(0, 63)),
          10'($urandom_range(0, 63)), 16'd4, 4, 0, 1, r == 0);

    got_q.delete();
    @(negedge clk);
    cfg_out_base_addr = 20'h200;
    cfg_co_groups = 10'd4;
    cfg_output_group = 10'd1;
    cfg_out_pixels = 16'd3;
    start = 1;
    wr_ready = 0;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 3; i++) begin
      data_in = {$urandom, $urandom};
      data_in_valid = 1;
      @(negedge clk);
    end
    data_in_valid = 0;
    @(negedge clk);
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    rst_n = 0;
    #1;
    chk("rst_mid_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    wr_ready = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_writes", 64'(got_q.size()), 64'd0);

    run("after_reset", 20'h100, 10'd16, 10'd3, 16'd4, 4, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
